// File: rtl/parity_scan_monitor.sv
// Parity scan monitor: checks even parity on a full address sweep of beats,
// counting mismatches, capturing the first bad address and flagging out-of-order beats.
module parity_scan_monitor #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid,
  output logic              seq_err,
  output logic              alarm
);

  localparam int unsigned     CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(1 << ADDR_W);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(ERR_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] exp_addr;
  logic              accept;
  logic              mismatch;
  logic              last_beat;
  logic [CNT_W-1:0]  err_inc;

  assign accept    = (state == SCAN) && in_valid;
  assign mismatch  = ^{in_data, in_parity};
  assign last_beat = accept && (exp_addr == LAST_ADDR);
  assign err_inc   = err_count + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status decoded from state
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      SCAN:    begin in_ready = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Scan results: cleared by an accepted start, updated per accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      seq_err         <= 1'b0;
      alarm           <= 1'b0;
      exp_addr        <= '0;
    end else if (state == IDLE && start) begin
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      seq_err         <= 1'b0;
      alarm           <= 1'b0;
      exp_addr        <= '0;
    end else if (accept) begin
      exp_addr <= exp_addr + ADDR_W'(1);
      if (in_addr != exp_addr) seq_err <= 1'b1;
      if (mismatch) begin
        if (err_count != CNT_MAX) begin
          err_count <= err_inc;
          if (err_inc == LIMIT) alarm <= 1'b1;
        end
        if (!first_err_valid) begin
          first_err_addr  <= in_addr;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_scan_monitor.sv
// Self-checking bench for parity_scan_monitor: directed scans plus a random phase,
// compared each cycle against a behavioural model of the scan rules.
module tb_parity_scan_monitor;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ERR_LIMIT = 3;
  localparam int          BEATS     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_parity;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, busy, done, first_err_valid, seq_err, alarm;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;

  parity_scan_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_parity(in_parity), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr), .first_err_valid(first_err_valid),
    .seq_err(seq_err), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: phase 0 idle, 1 scanning, 2 done cycle
  int m_phase, m_beats, m_errs, m_first;
  bit m_fv, m_seq, m_alarm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_beats = 0; m_errs = 0; m_first = 0; m_fv = 0; m_seq = 0; m_alarm = 0;
  endtask

  task automatic model_edge();
    bit bad;
    if (reset) begin
      m_phase = 0;
      model_clear();
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; model_clear(); end
        1: if (in_valid) begin
          bad = ($countones({in_data, in_parity}) % 2) == 1;
          if (int'(in_addr) != m_beats) m_seq = 1;
          if (bad) begin
            if (m_errs < BEATS) m_errs++;
            if (m_errs == ERR_LIMIT) m_alarm = 1;
            if (!m_fv) begin m_fv = 1; m_first = int'(in_addr); end
          end
          m_beats++;
          if (m_beats == BEATS) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic check_all();
    check("in_ready",        32'(in_ready),        32'(m_phase == 1));
    check("busy",            32'(busy),            32'(m_phase == 1));
    check("done",            32'(done),            32'(m_phase == 2));
    check("err_count",       32'(err_count),       32'(m_errs));
    check("first_err_addr",  32'(first_err_addr),  32'(m_first));
    check("first_err_valid", 32'(first_err_valid), 32'(m_fv));
    check("seq_err",         32'(seq_err),         32'(m_seq));
    check("alarm",           32'(alarm),           32'(m_alarm));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic beat(input int addr, input bit corrupt);
    in_valid  = 1'b1;
    in_addr   = ADDR_W'(addr);
    in_data   = DATA_W'($urandom);
    in_parity = (^in_data) ^ corrupt;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_parity = 1'b0;
    m_phase = 0; model_clear();
    tick();
    reset = 1'b0;
    idle(2);

    // Known-good word: 8'h1F with parity 1 is even over 9 bits
    do_start();
    in_valid = 1'b1; in_addr = '0; in_data = 8'h1F; in_parity = 1'b1; tick(); in_valid = 1'b0;
    for (int i = 1; i < BEATS; i++) beat(i, 0);
    check("clean_done_pulse", 32'(done), 32'd1);
    idle(2);

    // Parity errors at 5, 9, 12 with alarm at the third
    do_start();
    for (int i = 0; i < BEATS; i++) beat(i, (i == 5) || (i == 9) || (i == 12));
    check("err_first_addr", 32'(first_err_addr), 32'd5);
    check("err_alarm_after_done", 32'(alarm), 32'd1);
    idle(2);

    // Backpressure: 3 idle cycles between beats
    do_start();
    for (int i = 0; i < BEATS; i++) begin
      beat(i, i == 3);
      if (i != BEATS - 1) idle(3);
    end
    idle(2);

    // Sequence error: address 2 skipped
    do_start();
    for (int i = 0; i < BEATS; i++) beat((i < 2) ? i : i + 1, 0);
    idle(2);

    // Reset mid-scan after 7 beats with 2 errors, then a clean scan
    do_start();
    for (int i = 0; i < 7; i++) beat(i, (i == 1) || (i == 4));
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_err_count", 32'(err_count), 32'd0);
    do_start();
    for (int i = 0; i < BEATS; i++) beat(i, 0);
    idle(1);

    // Starts during SCAN and DONE ignored, start in IDLE clears
    do_start();
    for (int i = 0; i < BEATS; i++) begin
      start = (i == 6);
      beat(i, (i == 2) || (i == 7));
    end
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_done_kept", 32'(err_count), 32'd2);
    idle(1);
    do_start();
    check("start_idle_clears", 32'(err_count), 32'd0);
    for (int i = 0; i < BEATS; i++) beat(i, 0);
    idle(1);

    // Reset has priority over start
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    idle(1);

    // Random phase
    for (int n = 0; n < 1500; n++) begin
      start     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = ($urandom_range(0, 19) == 0) ? ADDR_W'($urandom) : ADDR_W'(m_beats);
      in_data   = DATA_W'($urandom);
      in_parity = (^in_data) ^ ($urandom_range(0, 5) == 0);
      tick();
    end
    start = 1'b0; reset = 1'b0; in_valid = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
